// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage feeding the Mealy sequence detectors.
// A one-word holding register lets back-to-back words stream without gap bits.
module piso_bit_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sout,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             active_q, active_d;
    logic             hold_full_q, hold_full_d;
    logic [CNT_W-1:0] ws_q, ws_d;
    logic             last;
    logic             accept;

    assign last       = active_q && (cnt_q == LAST_CNT);
    assign accept     = data_valid && !hold_full_q;

    assign data_ready = ~hold_full_q;
    assign bit_valid  = active_q;
    assign word_done  = last;
    assign busy       = active_q | hold_full_q;
    assign words_sent = ws_q;
    assign sout       = active_q ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0])
                                 : IDLE_BIT;

    always_comb begin
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        active_d    = active_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ws_d        = ws_q;

        if (!active_q || last) begin
            if (hold_full_q) begin
                sh_d        = hold_q;
                cnt_d       = '0;
                active_d    = 1'b1;
                hold_full_d = 1'b0;
            end else begin
                active_d = 1'b0;
            end
        end else begin
            sh_d  = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
            cnt_d = cnt_q + 1'b1;
        end

        if (last && (ws_q != '1)) begin
            ws_d = ws_q + 1'b1;
        end

        // Accept only lands while hold is empty, so it never races the transfer
        if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q        <= '0;
            cnt_q       <= '0;
            active_q    <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ws_q        <= '0;
        end else begin
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ws_q        <= ws_d;
        end
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: three configurations against a
// bit-queue reference model, with directed and random traffic.
module tb_piso_bit_serializer;

    logic       clk;
    logic       reset;
    logic [3:0] din [3];
    logic [2:0] dv;
    logic [2:0] rdy, so, bv, wd, bs;
    logic [15:0] ws0, ws2;
    logic [1:0]  ws1;

    piso_bit_serializer #(
        .WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)
    ) u0 (
        .clk(clk), .reset(reset), .data_in(din[0]), .data_valid(dv[0]),
        .data_ready(rdy[0]), .sout(so[0]), .bit_valid(bv[0]),
        .word_done(wd[0]), .busy(bs[0]), .words_sent(ws0)
    );

    piso_bit_serializer #(
        .WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .CNT_W(2)
    ) u1 (
        .clk(clk), .reset(reset), .data_in(din[1]), .data_valid(dv[1]),
        .data_ready(rdy[1]), .sout(so[1]), .bit_valid(bv[1]),
        .word_done(wd[1]), .busy(bs[1]), .words_sent(ws1)
    );

    piso_bit_serializer #(
        .WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)
    ) u2 (
        .clk(clk), .reset(reset), .data_in(din[2][0:0]), .data_valid(dv[2]),
        .data_ready(rdy[2]), .sout(so[2]), .bit_valid(bv[2]),
        .word_done(wd[2]), .busy(bs[2]), .words_sent(ws2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: bits still to appear on sout (front = current bit)
    bit         bq [3][$];
    logic [3:0] pq [3][$];
    logic [3:0] hw [3];
    bit         holdf [3];
    int         mws [3];
    bit         rnd [3];
    logic [2:0] acc;
    int         run [3];
    int         maxrun [3];
    logic [3:0] rec0, rec1;

    function automatic int wof(int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic bit msbof(int i);
        return i != 1;
    endfunction

    function automatic bit idleof(int i);
        return i == 1;
    endfunction

    function automatic int cmax(int i);
        return (i == 1) ? 3 : 65535;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            bq[i].delete();
            pq[i].delete();
            holdf[i] = 0;
            hw[i] = '0;
            mws[i] = 0;
        end
    endtask

    task automatic model_edge(int i);
        int w;
        logic [3:0] h;
        w = wof(i);
        if (bq[i].size() > 0) begin
            void'(bq[i].pop_front());
            if (bq[i].size() == 0 && mws[i] < cmax(i)) mws[i]++;
        end
        if (bq[i].size() == 0 && holdf[i]) begin
            h = hw[i];
            for (int k = 0; k < w; k++)
                bq[i].push_back(msbof(i) ? h[w-1-k] : h[k]);
            holdf[i] = 0;
        end
        if (acc[i]) begin
            hw[i] = din[i];
            holdf[i] = 1;
        end
    endtask

    task automatic check_outs(int i);
        int n;
        logic [31:0] aws;
        n = bq[i].size();
        case (i)
            0:       aws = 32'(ws0);
            1:       aws = 32'(ws1);
            default: aws = 32'(ws2);
        endcase
        check($sformatf("bit_valid[%0d]", i), 32'(bv[i]), 32'(n > 0));
        check($sformatf("sout[%0d]", i), 32'(so[i]),
              32'((n > 0) ? bq[i][0] : idleof(i)));
        check($sformatf("word_done[%0d]", i), 32'(wd[i]), 32'(n == 1));
        check($sformatf("data_ready[%0d]", i), 32'(rdy[i]), 32'(!holdf[i]));
        check($sformatf("busy[%0d]", i), 32'(bs[i]),
              32'((n > 0) || holdf[i]));
        check($sformatf("words_sent[%0d]", i), aws, 32'(mws[i]));
    endtask

    task automatic produce(int i);
        if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        if (pq[i].size() > 0) begin
            dv[i]  = 1'b1;
            din[i] = pq[i][0];
        end else if (rnd[i]) begin
            if (!(dv[i] && !acc[i])) begin
                dv[i]  = ($urandom_range(0, 3) != 0);
                din[i] = 4'($urandom);
            end
        end else begin
            dv[i]  = 1'b0;
            din[i] = 4'($urandom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            acc[i] = dv[i] && !holdf[i] && !reset;
            if (!reset) model_edge(i);
        end
        #1;
        for (int i = 0; i < 3; i++) produce(i);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_outs(i);
            if (bv[i]) run[i]++;
            else run[i] = 0;
            if (run[i] > maxrun[i]) maxrun[i] = run[i];
        end
        if (bv[0]) rec0 = {rec0[2:0], so[0]};
        if (bv[1]) rec1 = {rec1[2:0], so[1]};
    endtask

    initial begin
        int guard;
        reset = 1'b1;
        dv = '0;
        acc = '0;
        rec0 = '0;
        rec1 = '0;
        for (int i = 0; i < 3; i++) begin
            din[i] = '0;
            rnd[i] = 0;
            run[i] = 0;
            maxrun[i] = 0;
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_outs(i);
        reset = 1'b0;

        // Single word on MSB-first and LSB-first/idle-high instances
        pq[0].push_back(4'b1101);
        pq[1].push_back(4'b1011);
        for (int c = 0; c < 8; c++) step();
        check("msb_seq", 32'(rec0), 32'hD);
        check("lsb_seq", 32'(rec1), 32'hD);
        check("ws0_one", 32'(ws0), 32'd1);
        check("ws1_one", 32'(ws1), 32'd1);

        // Back-to-back stream, saturating counter, WIDTH=1 streaming
        for (int i = 0; i < 3; i++) maxrun[i] = 0;
        pq[0].push_back(4'b1101);
        pq[0].push_back(4'b1101);
        pq[0].push_back(4'b0110);
        for (int k = 0; k < 4; k++) pq[1].push_back(4'($urandom));
        for (int k = 0; k < 10; k++) pq[2].push_back(4'($urandom));
        for (int c = 0; c < 26; c++) step();
        check("stream_run", 32'(maxrun[0]), 32'd12);
        check("ws0_stream", 32'(ws0), 32'd4);
        check("ws1_sat", 32'(ws1), 32'd3);

        // Reset during the 2nd bit with a second word held
        pq[0].push_back(4'b1001);
        pq[0].push_back(4'b0111);
        guard = 0;
        while (!(bq[0].size() == 3 && holdf[0]) && guard < 20) begin
            step();
            guard++;
        end
        check("rst_setup_timeout", 32'(guard < 20), 32'd1);
        reset = 1'b1;
        dv = '0;
        model_clear();
        #1;
        check("rst_sout", 32'(so[0]), 32'd0);
        check("rst_bv", 32'(bv[0]), 32'd0);
        check("rst_rdy", 32'(rdy[0]), 32'd1);
        check("rst_busy", 32'(bs[0]), 32'd0);
        check("rst_ws", 32'(ws0), 32'd0);
        for (int i = 0; i < 3; i++) check_outs(i);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_outs(i);
        reset = 1'b0;
        rec0 = '0;
        pq[0].push_back(4'b1010);
        for (int c = 0; c < 8; c++) step();
        check("post_rst_seq", 32'(rec0), 32'hA);
        check("post_rst_ws", 32'(ws0), 32'd1);

        // Random traffic with stalls and garbage data while invalid
        for (int i = 0; i < 3; i++) rnd[i] = 1;
        for (int c = 0; c < 400; c++) step();
        for (int i = 0; i < 3; i++) rnd[i] = 0;
        for (int c = 0; c < 8; c++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the Mealy sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on sout, which drives the detector's din.
- A one-word holding register lets back-to-back words stream with no gap bits, so detector patterns can straddle word boundaries.
- When no word is in flight, sout carries a programmable idle level.

Parameters:
- WIDTH, 4, word width in bits; legal range >= 1.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 1'b0, value driven on sout while no word is being shifted.
- CNT_W, 16, width of the words_sent counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word to serialize.
- data_valid  input  1  data_in is valid this cycle.
- data_ready  output  1  holding register empty; word accepted at posedge when data_valid && data_ready.
- sout  output  1  serial bit, intended to drive the detector's din.
- bit_valid  output  1  sout carries payload; low means sout = IDLE_BIT.
- word_done  output  1  high while the last bit of the current word is on sout.
- busy  output  1  shifter active or holding register full.
- words_sent  output  CNT_W  count of fully shifted words; saturates at all-ones.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- State:
  - shift register sh[WIDTH-1:0]
  - bit counter cnt (0..WIDTH-1)
  - flag active
  - holding register hold[WIDTH-1:0]
  - flag hold_full
  - counter words_sent
- Reset (async, immediate):
  - active=0, hold_full=0, cnt=0, sh=0, hold=0, words_sent=0.
  - Outputs therefore: sout=IDLE_BIT, bit_valid=0, word_done=0, busy=0, data_ready=1.
- Combinational outputs:
  - data_ready = ~hold_full.
  - bit_valid = active.
  - sout = active ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_BIT.
  - word_done = active && cnt==WIDTH-1.
  - busy = active | hold_full.
- Per posedge, let last = active && cnt==WIDTH-1:
  - If !active or last:
    - hold_full=1: sh<=hold, cnt<=0, active<=1, hold_full<=0.
    - Otherwise: active<=0.
  - Else: sh shifts by one toward the output end (left if MSB_FIRST, right otherwise), cnt<=cnt+1.
  - If last: words_sent increments unless it is all-ones.
  - Accept: if data_valid && data_ready, then hold<=data_in and hold_full<=1.
    - The accept and the hold-to-shifter transfer never collide, because data_ready=0 whenever hold_full=1.
- Latency:
  - Word accepted at edge k is in hold after k, is loaded into sh at edge k+1, and its first bit is on sout during cycle k+1..k+2.
  - Its bits occupy WIDTH consecutive cycles.
- Throughput:
  - Continuous for any WIDTH >= 1 when data_valid is held high.
  - For WIDTH=1, hold is refilled and drained every cycle.
- data_in is sampled only at the accept edge; later changes have no effect.
- Holding data_valid high with data_ready low stalls the producer without loss.
- Reset mid-word: the partial word and the held word are discarded; no further bits are emitted.
- The FSM is implicit in (active, hold_full):
  - IDLE (0,0)
  - HELD (0,1), transient for one cycle
  - SHIFT (1,0)
  - SHIFT_HELD (1,1)

Test Plan:
- Reset, then data_in=4'b1101, data_valid for 1 cycle (WIDTH=4, MSB_FIRST=1) -> sout=1,1,0,1 on cycles 2..5 with bit_valid=1, word_done only on cycle 5, words_sent=1. Chained to the detector, its dout pulses during cycle 5.
- data_valid held high with words 1101, 1101, 0110 -> 12 contiguous bit_valid cycles with no idle gaps. data_ready drops after each accept and returns on the edge hold empties. words_sent=3 after the stream.
- MSB_FIRST=0, word 4'b1011 -> sout=1,1,0,1; IDLE_BIT=1 -> sout=1 and bit_valid=0 before and after the word.
- Assert reset during the 2nd bit while a second word is held -> immediately sout=IDLE_BIT, bit_valid=0, data_ready=1, busy=0, words_sent=0; the next accepted word serializes cleanly from bit 0.
- CNT_W=2, stream 5 words -> words_sent reads 1, 2, 3, 3, 3 (saturation). WIDTH=1 with data_valid always high -> bit_valid stays 1 continuously after the first load.
